// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter and its bit timer.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int   CLKS_PER_BIT_DEF = 16;
  localparam logic IDLE_LEVEL       = 1'b1;
  localparam int   PAR_MAX_W        = 32;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fifo_uart_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
module uart_bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic bit_tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         cnt <= '0;
    else if (load)    cnt <= '0;
    else if (en)      cnt <= bit_tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a sync FIFO one byte at a time and serializes each as a UART frame on tx.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int             BCW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  state_t            state, state_n;
  logic [BCW-1:0]    bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              par_q, par_n;
  logic              tx_n;
  logic              bit_tick;
  logic              tmr_load;

  assign tmr_load = (state == IDLE) || (state == WAIT);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (!tmr_load),
    .bit_tick (bit_tick)
  );

  // tx is registered from the next-state view so the line changes exactly on state entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      tx      <= IDLE_LEVEL;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par_q   <= par_n;
      tx      <= tx_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par_q;
    case (state)
      IDLE: if (fifo_rd_en) state_n = WAIT;
      WAIT: begin
        shreg_n = fifo_data;
        par_n   = even_parity(PAR_MAX_W'(fifo_data));
        state_n = START;
      end
      START: if (bit_tick) begin
        state_n   = DATA;
        bit_cnt_n = '0;
      end
      DATA: if (bit_tick) begin
        shreg_n = shreg >> 1;
        if (bit_cnt == LAST_DATA) begin
          bit_cnt_n = '0;
          state_n   = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      PARITY: if (bit_tick) begin
        state_n   = STOP;
        bit_cnt_n = '0;
      end
      STOP: if (bit_tick) begin
        if (bit_cnt == LAST_STOP) begin
          state_n   = IDLE;
          bit_cnt_n = '0;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pop only from IDLE (and never while reset is held) so each frame costs exactly one pop.
  always_comb begin
    fifo_rd_en = (state == IDLE) && tx_en && !fifo_empty && rst;
    busy       = (state != IDLE);
    byte_done  = (state == STOP) && bit_tick && (bit_cnt == LAST_STOP);
    tx_n       = IDLE_LEVEL;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeds two instances, a per-instance monitor decodes tx frames.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] data;
    bit         abort;
    bit         b2b;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            tx_en;
  logic [1:0]      fifo_empty;
  logic [1:0][7:0] fifo_data;
  logic [1:0]      rd, txl, busy, done;

  logic [7:0] fq[$];
  exp_t       exp_q[$];
  int         sel;
  int         checks = 0;
  int         errors = 0;
  int         pops[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam int NB = 10 + 2 * g;

    fifo_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .DATA_W       (8),
      .PARITY_EN    (g),
      .STOP_BITS    (g + 1)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_en      (tx_en),
      .fifo_empty (fifo_empty[g]),
      .fifo_rd_en (rd[g]),
      .fifo_data  (fifo_data[g]),
      .tx         (txl[g]),
      .busy       (busy[g]),
      .byte_done  (done[g])
    );

    // Decode every frame seen on tx and compare it to the next queued expectation.
    initial begin : mon
      exp_t          e;
      logic [NB-1:0] bits;
      bit            ab, slot_ok, done_ok;
      logic          bad_v;
      time           t_done, t_start;
      t_done = 0;
      forever begin
        @(negedge clk);
        if (rst === 1'b1 && txl[g] === 1'b0) begin
          t_start = $time;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_unexpected ch%0d: start bit with no queued byte", g);
            e = '{8'h00, 1'b0, 1'b0};
          end else begin
            e = exp_q.pop_front();
          end
          if (e.b2b) begin
            checks++;
            if (t_start - t_done != 30) begin
              errors++;
              $display("FAIL gap ch%0d byte %h: start %0t after done, required 30", g, e.data, t_start - t_done);
            end
          end
          if (g == 1) bits = NB'({3'b111, ^e.data, e.data, 1'b0});
          else        bits = NB'({3'b111, e.data, 1'b0});
          ab = 1'b0; done_ok = 1'b1; bad_v = 1'b0;
          for (int s = 0; s < NB && !ab; s++) begin
            slot_ok = 1'b1;
            for (int c = 0; c < CPB; c++) begin
              if (s > 0 || c > 0) @(negedge clk);
              if (rst !== 1'b1) begin ab = 1'b1; break; end
              if (txl[g] !== bits[s]) begin slot_ok = 1'b0; bad_v = txl[g]; end
              if (done[g] !== ((s == NB - 1) && (c == CPB - 1))) done_ok = 1'b0;
            end
            if (!ab) begin
              checks++;
              if (!slot_ok) begin
                errors++;
                $display("FAIL tx_bit ch%0d byte %h slot %0d: tx=%b required %b", g, e.data, s, bad_v, bits[s]);
              end
            end
          end
          checks++;
          if (ab != e.abort) begin
            errors++;
            $display("FAIL frame_abort ch%0d byte %h: aborted=%0d required %0d", g, e.data, ab, e.abort);
          end
          if (!ab) begin
            t_done = $time;
            checks++;
            if (!done_ok) begin
              errors++;
              $display("FAIL byte_done ch%0d byte %h: pulse not confined to cycle %0d of frame", g, e.data, NB * CPB - 1);
            end
            @(negedge clk);
            checks++;
            if (busy[g] !== 1'b0) begin
              errors++;
              $display("FAIL busy_after ch%0d byte %h: busy=%b required 0", g, e.data, busy[g]);
            end
          end
        end
      end
    end
  end

  // FIFO read side: data appears the cycle after the pop; popping empty is an error.
  initial begin
    fifo_empty = '1;
    fifo_data  = '0;
    pops[0] = 0; pops[1] = 0;
    forever begin
      @(posedge clk);
      for (int c = 0; c < 2; c++) begin
        if (rd[c] === 1'b1) begin
          checks++;
          if (fq.size() == 0) begin
            errors++;
            $display("FAIL pop_empty ch%0d: pop with model FIFO empty, required no pop", c);
          end else begin
            fifo_data[c] <= fq.pop_front();
            pops[c]++;
          end
        end
      end
      #1;
      for (int c = 0; c < 2; c++) fifo_empty[c] = (sel != c) || (fq.size() == 0);
    end
  end

  task automatic push(input logic [7:0] d, input bit ab, input bit b2b);
    fq.push_back(d);
    exp_q.push_back('{d, ab, b2b});
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && busy === 2'b00) && n < budget);
    if (!(exp_q.size() == 0 && busy === 2'b00)) begin
      checks++; errors++;
      $display("FAIL timeout_idle: still busy after %0d cycles", budget);
    end
  endtask

  task automatic wait_start(input int ch, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txl[ch] !== 1'b0 && n < budget);
    if (txl[ch] !== 1'b0) begin
      checks++; errors++;
      $display("FAIL timeout_start ch%0d: no start bit within %0d cycles", ch, budget);
    end
  endtask

  // Count cycles from the first low cycle to byte_done; returns frame length in cycles.
  task automatic frame_len(input int ch, input int par_k, output int len);
    int k = 0;
    while (done[ch] !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
      if (par_k >= 0 && k == par_k) check1("t6_parity_bit", txl[ch], 1'b1);
    end
    len = k + 1;
  endtask

  initial begin
    int len;
    rst = 1'b0; tx_en = 1'b1; sel = 0;

    // 1: reset held with data available
    push(8'hA5, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check1("reset_tx", txl[0], 1'b1);
      check1("reset_rd_en", rd[0], 1'b0);
      check1("reset_busy", busy[0], 1'b0);
      check1("reset_byte_done", done[0], 1'b0);
    end
    @(posedge clk); #2 rst = 1'b1;

    // 2: single byte 0xA5, 40-cycle frame
    wait_start(0, 20);
    frame_len(0, -1, len);
    check_int("t2_frame_len", len, 40);
    wait_idle(200);
    check_int("t2_pops", pops[0], 1);

    // 3: back-to-back frames with a 2-cycle gap
    @(posedge clk); #2;
    push(8'h01, 1'b0, 1'b0);
    push(8'h02, 1'b0, 1'b1);
    push(8'h03, 1'b0, 1'b1);
    wait_idle(600);
    repeat (20) @(negedge clk);
    check_int("t3_pops", pops[0], 4);

    // 4: empty FIFO, then data present but disabled
    repeat (100) begin
      @(negedge clk);
      check1("t4_empty_rd_en", rd[0], 1'b0);
      check1("t4_empty_tx", txl[0], 1'b1);
    end
    tx_en = 1'b0;
    push(8'h55, 1'b0, 1'b0);
    push(8'hC3, 1'b1, 1'b0);
    push(8'h96, 1'b0, 1'b0);
    repeat (100) begin
      @(negedge clk);
      check1("t4_disabled_rd_en", rd[0], 1'b0);
      check1("t4_disabled_tx", txl[0], 1'b1);
    end

    // 5a: tx_en dropped during data bit 3 of 0x55
    tx_en = 1'b1;
    wait_start(0, 20);
    repeat (16) @(negedge clk);
    tx_en = 1'b0;
    repeat (60) @(negedge clk);
    check_int("t5_no_pop_after_disable", pops[0], 5);
    check1("t5_idle_busy", busy[0], 1'b0);

    // 5b: reset during data bit 5 of 0xC3 (bit value 0)
    tx_en = 1'b1;
    wait_start(0, 20);
    repeat (25) @(negedge clk);
    check1("t5_bit5_low", txl[0], 1'b0);
    #1 rst = 1'b0;
    #1 check1("t5_async_tx_high", txl[0], 1'b1);
    check1("t5_async_busy", busy[0], 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    wait_idle(200);
    check_int("t5_pops", pops[0], 7);

    // 6: parity + two stop bits on the second instance, byte 0x07
    sel = 1;
    push(8'h07, 1'b0, 1'b0);
    wait_start(1, 20);
    frame_len(1, 38, len);
    check_int("t6_frame_len", len, 48);
    wait_idle(200);
    check_int("t6_pops", pops[1], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
